// File: rtl/ofs_plat_avalon_mem_if_buffer_pkg.sv
// Shared constants for the Avalon-MM request/response buffer: response codes
// and statistics counter width, plus a saturating increment helper.
package ofs_plat_avalon_mem_if_buffer_pkg;

  localparam logic [1:0] OKAY      = 2'b00;
  localparam logic [1:0] RESERVED  = 2'b01;
  localparam logic [1:0] SLVERR    = 2'b10;
  localparam logic [1:0] DECODEERR = 2'b11;

  localparam int STATS_CNT_WIDTH = 32;

  function automatic logic [STATS_CNT_WIDTH-1:0] sat_inc(input logic [STATS_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ofs_plat_avalon_mem_req_fifo.sv
// Generic N_DATA_BITS x REQ_DEPTH request FIFO with registered full flag and
// occupancy count. No bypass: a push into an empty FIFO is visible next cycle.
module ofs_plat_avalon_mem_req_fifo #(
  parameter int N_DATA_BITS = 8,
  parameter int REQ_DEPTH   = 4,
  localparam int PTR_W = $clog2(REQ_DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [N_DATA_BITS-1:0] push_data,
  input  logic                   pop,
  output logic [N_DATA_BITS-1:0] head_data,
  output logic                   head_valid,
  output logic                   full,
  output logic [CNT_W-1:0]       count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(REQ_DEPTH);

  logic [N_DATA_BITS-1:0] mem [REQ_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count_next;
  logic                   do_push;
  logic                   do_pop;

  assign head_valid = (count != '0);
  assign do_push    = push & ~full;
  assign do_pop     = pop & head_valid;
  assign head_data  = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop)
      count_next = count + 1'b1;
    else if (!do_push && do_pop)
      count_next = count - 1'b1;
  end

  // full is held high through reset so the source is stalled until the first
  // clock after release; pointers wrap naturally as REQ_DEPTH is a power of 2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ofs_plat_avalon_mem_if_buffer.sv
// Avalon-MM source->sink buffer: REQ_DEPTH request FIFO and RSP_STAGES response
// registers. Define OFS_PLAT_AVALON_MEM_IF_BUFFER_STATS_EN for occupancy/stall stats.
module ofs_plat_avalon_mem_if_buffer
  import ofs_plat_avalon_mem_if_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7,
  parameter int USER_WIDTH      = 1,
  parameter int REQ_DEPTH       = 4,
  parameter int RSP_STAGES      = 1,
  localparam int DATA_N_BYTES = DATA_WIDTH / 8,
  localparam int CNT_W        = $clog2(REQ_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       reset_n,

  output logic                       src_waitrequest,
  input  logic                       src_read,
  input  logic                       src_write,
  input  logic [ADDR_WIDTH-1:0]      src_address,
  input  logic [BURST_CNT_WIDTH-1:0] src_burstcount,
  input  logic [DATA_WIDTH-1:0]      src_writedata,
  input  logic [DATA_N_BYTES-1:0]    src_byteenable,
  input  logic [USER_WIDTH-1:0]      src_user,
  output logic                       src_readdatavalid,
  output logic [DATA_WIDTH-1:0]      src_readdata,
  output logic                       src_writeresponsevalid,
  output logic [1:0]                 src_response,
  output logic [USER_WIDTH-1:0]      src_rsp_user,

  input  logic                       snk_waitrequest,
  output logic                       snk_read,
  output logic                       snk_write,
  output logic [ADDR_WIDTH-1:0]      snk_address,
  output logic [BURST_CNT_WIDTH-1:0] snk_burstcount,
  output logic [DATA_WIDTH-1:0]      snk_writedata,
  output logic [DATA_N_BYTES-1:0]    snk_byteenable,
  output logic [USER_WIDTH-1:0]      snk_user,
  input  logic                       snk_readdatavalid,
  input  logic [DATA_WIDTH-1:0]      snk_readdata,
  input  logic                       snk_writeresponsevalid,
  input  logic [1:0]                 snk_response,
  input  logic [USER_WIDTH-1:0]      snk_rsp_user
`ifdef OFS_PLAT_AVALON_MEM_IF_BUFFER_STATS_EN
  ,
  output logic [CNT_W-1:0]           stat_max_occupancy,
  output logic [STATS_CNT_WIDTH-1:0] stat_stall_cycles
`endif
);

  localparam int REQ_W = BURST_CNT_WIDTH + DATA_WIDTH + ADDR_WIDTH + 2 + DATA_N_BYTES + USER_WIDTH;

  logic             src_req;
  logic             push;
  logic             pop;
  logic             head_valid;
  logic             head_read;
  logic             head_write;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
  logic [REQ_W-1:0] req_payload;
  logic [REQ_W-1:0] head_payload;

  // Handshake: a request transfers on a clock where its strobe is high and
  // waitrequest is low; while waitrequest is high the requester holds strobe
  // and payload unchanged. Responses carry no back-pressure.
  assign src_req     = src_read | src_write;
  assign push        = src_req & ~src_waitrequest;
  assign pop         = head_valid & ~snk_waitrequest;
  assign req_payload = {src_burstcount, src_writedata, src_address,
                        src_write, src_read, src_byteenable, src_user};

  ofs_plat_avalon_mem_req_fifo #(
    .N_DATA_BITS (REQ_W),
    .REQ_DEPTH   (REQ_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .push_data  (req_payload),
    .pop        (pop),
    .head_data  (head_payload),
    .head_valid (head_valid),
    .full       (fifo_full),
    .count      (fifo_count)
  );

  assign src_waitrequest = fifo_full;
  assign {snk_burstcount, snk_writedata, snk_address,
          head_write, head_read, snk_byteenable, snk_user} = head_payload;
  assign snk_read  = head_valid & head_read;
  assign snk_write = head_valid & head_write;

  generate
    if (RSP_STAGES == 0) begin : g_rsp_bypass
      assign src_readdatavalid      = snk_readdatavalid;
      assign src_writeresponsevalid = snk_writeresponsevalid;
      assign src_readdata           = snk_readdata;
      assign src_response           = snk_response;
      assign src_rsp_user           = snk_rsp_user;
    end else begin : g_rsp_pipe
      logic [RSP_STAGES-1:0] rd_vld_q;
      logic [RSP_STAGES-1:0] wr_vld_q;
      logic [DATA_WIDTH-1:0] rdata_q [RSP_STAGES];
      logic [1:0]            resp_q  [RSP_STAGES];
      logic [USER_WIDTH-1:0] ruser_q [RSP_STAGES];

      // Only the valids are reset; payload simply follows the pipeline.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rd_vld_q <= '0;
          wr_vld_q <= '0;
        end else begin
          rd_vld_q[0] <= snk_readdatavalid;
          wr_vld_q[0] <= snk_writeresponsevalid;
          for (int i = 1; i < RSP_STAGES; i++) begin
            rd_vld_q[i] <= rd_vld_q[i-1];
            wr_vld_q[i] <= wr_vld_q[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        rdata_q[0] <= snk_readdata;
        resp_q[0]  <= snk_response;
        ruser_q[0] <= snk_rsp_user;
        for (int i = 1; i < RSP_STAGES; i++) begin
          rdata_q[i] <= rdata_q[i-1];
          resp_q[i]  <= resp_q[i-1];
          ruser_q[i] <= ruser_q[i-1];
        end
      end

      assign src_readdatavalid      = rd_vld_q[RSP_STAGES-1];
      assign src_writeresponsevalid = wr_vld_q[RSP_STAGES-1];
      assign src_readdata           = rdata_q[RSP_STAGES-1];
      assign src_response           = resp_q[RSP_STAGES-1];
      assign src_rsp_user           = ruser_q[RSP_STAGES-1];
    end
  endgenerate

`ifdef OFS_PLAT_AVALON_MEM_IF_BUFFER_STATS_EN
  logic [CNT_W-1:0]           max_occ_q;
  logic [STATS_CNT_WIDTH-1:0] stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      max_occ_q <= '0;
      stall_q   <= '0;
    end else begin
      if (fifo_count > max_occ_q) max_occ_q <= fifo_count;
      if (head_valid && snk_waitrequest) stall_q <= sat_inc(stall_q);
    end
  end

  assign stat_max_occupancy = max_occ_q;
  assign stat_stall_cycles  = stall_q;
`endif

`ifndef SYNTHESIS
  a_rw_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
    !(src_read && src_write));
  a_src_hold: assert property (@(posedge clk) disable iff (!reset_n)
    (src_req && src_waitrequest) |=> $stable(req_payload));
  a_count_range: assert property (@(posedge clk) disable iff (!reset_n)
    fifo_count <= CNT_W'(REQ_DEPTH));
`endif

endmodule
